// File: rtl/scr1_mdu_cmd_mon.sv
// scr1_mdu_cmd_mon: logs fetched RV32M MUL/DIV instructions into an event FIFO; SCR1_MDU_MON_CNT_EN adds per-class counters
module scr1_mdu_cmd_mon #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        clr,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [2:0]  evt_funct3,
  output logic [4:0]  evt_rs1,
  output logic [4:0]  evt_rs2,
  output logic [4:0]  evt_rd,
  output logic [15:0] evt_seq,
  output logic [4:0]  fifo_level,
  output logic        overflow,
  output logic [15:0] div_cnt,
  output logic [15:0] mul_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [33:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [4:0]    level;
  logic [15:0]   seq;
  logic          ovf, hit, full, pop, push;
  assign hit = imem_resp == 2'b01 && imem_rdata[6:0] == 7'b0110011 && imem_rdata[31:25] == 7'b0000001;
  assign full = level == 5'(FIFO_DEPTH);
  assign pop = evt_valid && evt_ready;
  assign push = hit && (!full || pop);
  assign evt_valid = level != 5'd0;
  assign {evt_funct3, evt_rs1, evt_rs2, evt_rd, evt_seq} = mem[rp];
  assign fifo_level = level;
  assign overflow = ovf;
  always_ff @(posedge clk)
    if (push) mem[wp] <= {imem_rdata[14:12], imem_rdata[19:15], imem_rdata[24:20], imem_rdata[11:7], seq};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
      seq <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
      seq <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      level <= level + 5'(push) - 5'(pop);
      if (hit) seq <= seq + 16'd1;
      if (hit && !push) ovf <= 1'b1;
    end
`ifdef SCR1_MDU_MON_CNT_EN
  logic [15:0] dcnt, mcnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dcnt <= '0;
      mcnt <= '0;
    end else if (clr) begin
      dcnt <= '0;
      mcnt <= '0;
    end else if (hit) begin
      if (imem_rdata[14] && dcnt != 16'hFFFF) dcnt <= dcnt + 16'd1;
      if (!imem_rdata[14] && mcnt != 16'hFFFF) mcnt <= mcnt + 16'd1;
    end
  assign div_cnt = dcnt;
  assign mul_cnt = mcnt;
`else
  assign div_cnt = 16'h0000;
  assign mul_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_scr1_mdu_cmd_mon.sv
// tb_scr1_mdu_cmd_mon: directed self-checking bench for scr1_mdu_cmd_mon (FIFO_DEPTH=4)
module tb_scr1_mdu_cmd_mon;
  logic        clk = 1'b0, rst = 1'b1, clr = 1'b0, evt_ready = 1'b0;
  logic [1:0]  imem_resp = 2'b00;
  logic [31:0] imem_rdata = 32'h0;
  logic        evt_valid, overflow;
  logic [2:0]  evt_funct3;
  logic [4:0]  evt_rs1, evt_rs2, evt_rd, fifo_level;
  logic [15:0] evt_seq, div_cnt, mul_cnt;
  int n_cmp = 0, n_err = 0;
`ifdef SCR1_MDU_MON_CNT_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif
  always #5 clk = ~clk;
  scr1_mdu_cmd_mon #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .imem_resp(imem_resp), .imem_rdata(imem_rdata), .clr(clr),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_funct3(evt_funct3), .evt_rs1(evt_rs1),
    .evt_rs2(evt_rs2), .evt_rd(evt_rd), .evt_seq(evt_seq), .fifo_level(fifo_level),
    .overflow(overflow), .div_cnt(div_cnt), .mul_cnt(mul_cnt)
  );
  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0000001, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic hit_cyc(input logic [31:0] w, input logic rdy);
    imem_resp = 2'b01;
    imem_rdata = w;
    evt_ready = rdy;
    step();
    imem_resp = 2'b00;
    evt_ready = 1'b0;
  endtask
  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask
  task automatic pop_one();
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
  endtask
  task automatic test_reset();
    #2;
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0d exp 0", evt_valid); end
    n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %0d exp 0", overflow); end
    n_cmp++; if (div_cnt !== 16'd0 || mul_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", div_cnt, mul_cnt); end
    step();
    step();
    rst = 1'b0;
    step();
  endtask
  task automatic test_single_hit();
    hit_cyc(32'h02C5C533, 1'b0);
    n_cmp++; if (evt_valid !== 1'b1) begin n_err++; $display("FAIL hit_valid got %0d exp 1", evt_valid); end
    n_cmp++; if (evt_funct3 !== 3'b100) begin n_err++; $display("FAIL hit_funct3 got %0d exp 4", evt_funct3); end
    n_cmp++; if (evt_rs1 !== 5'd11 || evt_rs2 !== 5'd12 || evt_rd !== 5'd10) begin n_err++; $display("FAIL hit_regs got %0d/%0d/%0d exp 11/12/10", evt_rs1, evt_rs2, evt_rd); end
    n_cmp++; if (evt_seq !== 16'd0) begin n_err++; $display("FAIL hit_seq got %0d exp 0", evt_seq); end
    n_cmp++; if (fifo_level !== 5'd1) begin n_err++; $display("FAIL hit_level got %0d exp 1", fifo_level); end
    n_cmp++; if (div_cnt !== (CNT ? 16'd1 : 16'd0) || mul_cnt !== 16'd0) begin n_err++; $display("FAIL hit_cnt got %0d/%0d exp %0d/0", div_cnt, mul_cnt, CNT); end
    step();
    n_cmp++; if (evt_valid !== 1'b1 || evt_rd !== 5'd10 || fifo_level !== 5'd1) begin n_err++; $display("FAIL hold_stable got v%0d rd%0d l%0d exp v1 rd10 l1", evt_valid, evt_rd, fifo_level); end
    pop_one();
    n_cmp++; if (evt_valid !== 1'b0 || fifo_level !== 5'd0) begin n_err++; $display("FAIL hit_pop got v%0d l%0d exp v0 l0", evt_valid, fifo_level); end
  endtask
  task automatic test_no_hit();
    imem_rdata = 32'h02C5C533;
    imem_resp = 2'b00;
    step();
    imem_resp = 2'b10;
    step();
    imem_resp = 2'b01;
    imem_rdata = 32'h00C5C533;
    step();
    imem_rdata = 32'h02C5C513;
    step();
    imem_resp = 2'b00;
    n_cmp++; if (evt_valid !== 1'b0 || fifo_level !== 5'd0) begin n_err++; $display("FAIL nohit_level got v%0d l%0d exp v0 l0", evt_valid, fifo_level); end
    hit_cyc(mk(3'd3, 5'd1, 5'd2, 5'd3), 1'b0);
    n_cmp++; if (evt_seq !== 16'd1) begin n_err++; $display("FAIL nohit_seq got %0d exp 1", evt_seq); end
    n_cmp++; if (mul_cnt !== (CNT ? 16'd1 : 16'd0)) begin n_err++; $display("FAIL nohit_mulcnt got %0d exp %0d", mul_cnt, CNT); end
    pop_one();
  endtask
  task automatic test_overflow();
    logic [2:0] f3t [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd6};
    do_clr();
    for (int i = 0; i < 5; i++) hit_cyc(mk(f3t[i], 5'(3 * i + 1), 5'(3 * i + 2), 5'(3 * i + 3)), 1'b0);
    n_cmp++; if (fifo_level !== 5'd4) begin n_err++; $display("FAIL ovf_level got %0d exp 4", fifo_level); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %0d exp 1", overflow); end
    n_cmp++; if (div_cnt !== (CNT ? 16'd3 : 16'd0) || mul_cnt !== (CNT ? 16'd2 : 16'd0)) begin n_err++; $display("FAIL ovf_cnt got %0d/%0d exp %0d/%0d", div_cnt, mul_cnt, CNT ? 3 : 0, CNT ? 2 : 0); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (evt_seq !== 16'(i) || evt_funct3 !== f3t[i] || evt_rd !== 5'(3 * i + 1) || evt_rs2 !== 5'(3 * i + 3)) begin n_err++; $display("FAIL ovf_pop%0d got seq%0d f%0d rd%0d rs2 %0d exp seq%0d f%0d rd%0d rs2 %0d", i, evt_seq, evt_funct3, evt_rd, evt_rs2, i, f3t[i], 3 * i + 1, 3 * i + 3); end
      pop_one();
    end
    n_cmp++; if (fifo_level !== 5'd0 || overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got l%0d o%0d exp l0 o1", fifo_level, overflow); end
    hit_cyc(mk(3'd2, 5'd9, 5'd9, 5'd9), 1'b0);
    n_cmp++; if (evt_seq !== 16'd5) begin n_err++; $display("FAIL ovf_nextseq got %0d exp 5", evt_seq); end
    pop_one();
  endtask
  task automatic test_full_pop();
    do_clr();
    for (int i = 0; i < 4; i++) hit_cyc(mk(3'(i), 5'(i), 5'(i), 5'(i)), 1'b0);
    hit_cyc(mk(3'd7, 5'd20, 5'd21, 5'd22), 1'b1);
    n_cmp++; if (fifo_level !== 5'd4 || overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_state got l%0d o%0d exp l4 o0", fifo_level, overflow); end
    for (int i = 1; i < 5; i++) begin
      n_cmp++; if (evt_seq !== 16'(i)) begin n_err++; $display("FAIL fullpop_seq got %0d exp %0d", evt_seq, i); end
      if (i == 4) begin
        n_cmp++; if (evt_funct3 !== 3'd7 || evt_rd !== 5'd20 || evt_rs1 !== 5'd21) begin n_err++; $display("FAIL fullpop_last got f%0d rd%0d rs1 %0d exp f7 rd20 rs1 21", evt_funct3, evt_rd, evt_rs1); end
      end
      pop_one();
    end
  endtask
  task automatic test_ready_empty();
    do_clr();
    hit_cyc(32'h02C5C533, 1'b1);
    n_cmp++; if (evt_valid !== 1'b1 || fifo_level !== 5'd1 || evt_seq !== 16'd0) begin n_err++; $display("FAIL rdyempty got v%0d l%0d s%0d exp v1 l1 s0", evt_valid, fifo_level, evt_seq); end
    pop_one();
    n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL rdyempty_pop got %0d exp 0", fifo_level); end
  endtask
  task automatic test_async_reset();
    do_clr();
    for (int i = 0; i < 3; i++) hit_cyc(mk(3'd4, 5'(i), 5'd1, 5'd2), 1'b0);
    n_cmp++; if (fifo_level !== 5'd3) begin n_err++; $display("FAIL arst_pre got %0d exp 3", fifo_level); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (evt_valid !== 1'b0 || fifo_level !== 5'd0) begin n_err++; $display("FAIL arst_async got v%0d l%0d exp v0 l0", evt_valid, fifo_level); end
    #2 rst = 1'b0;
    step();
    hit_cyc(mk(3'd1, 5'd3, 5'd4, 5'd5), 1'b0);
    n_cmp++; if (evt_seq !== 16'd0 || fifo_level !== 5'd1 || evt_rd !== 5'd3) begin n_err++; $display("FAIL arst_seq got s%0d l%0d rd%0d exp s0 l1 rd3", evt_seq, fifo_level, evt_rd); end
    pop_one();
  endtask
  task automatic test_clr_hit();
    for (int i = 0; i < 5; i++) hit_cyc(32'h02C5C533, 1'b0);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL clr_pre got %0d exp 1", overflow); end
    imem_resp = 2'b01;
    imem_rdata = 32'h02C5C533;
    evt_ready = 1'b1;
    clr = 1'b1;
    step();
    clr = 1'b0;
    imem_resp = 2'b00;
    evt_ready = 1'b0;
    n_cmp++; if (evt_valid !== 1'b0 || fifo_level !== 5'd0 || overflow !== 1'b0) begin n_err++; $display("FAIL clr_state got v%0d l%0d o%0d exp v0 l0 o0", evt_valid, fifo_level, overflow); end
    n_cmp++; if (div_cnt !== 16'd0 || mul_cnt !== 16'd0) begin n_err++; $display("FAIL clr_cnt got %0d/%0d exp 0/0", div_cnt, mul_cnt); end
    hit_cyc(mk(3'd0, 5'd1, 5'd1, 5'd1), 1'b0);
    n_cmp++; if (evt_seq !== 16'd0) begin n_err++; $display("FAIL clr_seq got %0d exp 0", evt_seq); end
    pop_one();
  endtask
  task automatic test_wrap();
    do_clr();
    imem_resp = 2'b01;
    imem_rdata = 32'h02C5C533;
    evt_ready = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      step();
      if (i == 65535) begin
        n_cmp++; if (evt_seq !== 16'hFFFF || fifo_level !== 5'd1) begin n_err++; $display("FAIL wrap_max got s%0h l%0d exp sffff l1", evt_seq, fifo_level); end
      end
    end
    imem_resp = 2'b00;
    evt_ready = 1'b0;
    n_cmp++; if (evt_seq !== 16'd0 || fifo_level !== 5'd1 || overflow !== 1'b0) begin n_err++; $display("FAIL wrap_seq got s%0d l%0d o%0d exp s0 l1 o0", evt_seq, fifo_level, overflow); end
    n_cmp++; if (div_cnt !== (CNT ? 16'hFFFF : 16'h0) || mul_cnt !== 16'd0) begin n_err++; $display("FAIL wrap_cnt got %0h/%0h exp %0h/0", div_cnt, mul_cnt, CNT ? 16'hFFFF : 16'h0); end
  endtask
  initial begin
    test_reset();
    test_single_hit();
    test_no_hit();
    test_overflow();
    test_full_pop();
    test_ready_empty();
    test_async_reset();
    test_clr_hit();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
